regfile_dump_reader: RTL

Sequential readout engine that walks every entry of a register file through one combinational read port and streams each value out over a val/rdy interface, tagged with its index. It consumes the read side of the `RegisterFile` block: the register file's write ports fill it, and this block drains a full snapshot for debug dump, checkpoint save, or test observation. A one-shot `start` method launches a dump; `out_last` flags the final beat.

---
 rtl/regfile_dump_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register file read port and streams each entry out with its index
// Optional trailing XOR checksum beat: define REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
    parameter int DTYPE = 8,
    parameter int NREGS = 4,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_call,
    output logic             start_rdy,
    output logic [AW-1:0]    rd_addr,
    input  logic [DTYPE-1:0] rd_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [DTYPE-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    output logic             out_last,
    output logic             busy
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, FETCH, SEND, CKSUM} state_t;
    logic [DTYPE-1:0] acc;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
`endif

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] ptr;

    assign rd_addr   = ptr;
    assign busy      = (state != IDLE);
    assign start_rdy = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            out_val  <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_call) begin
                        ptr   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc   <= '0;
`endif
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    out_data <= rd_data;
                    out_addr <= ptr;
                    out_val  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last <= 1'b0;
                    acc      <= acc ^ rd_data;
`else
                    out_last <= (ptr == LAST);
`endif
                    state    <= SEND;
                end
                SEND: begin
                    if (out_rdy) begin
                        if (ptr != LAST) begin
                            ptr     <= ptr + 1'b1;
                            out_val <= 1'b0;
                            state   <= FETCH;
                        end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // accumulator already holds the last register read in FETCH
                            out_data <= acc;
                            out_addr <= '0;
                            out_last <= 1'b1;
                            state    <= CKSUM;
`else
                            out_val  <= 1'b0;
                            out_last <= 1'b0;
                            state    <= IDLE;
`endif
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                CKSUM: begin
                    if (out_rdy) begin
                        out_val  <= 1'b0;
                        out_last <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
